fsk_hop_sequencer: RTL and testbench
====================================

FSK_HOP_SEQUENCER -- requirements
Module: fsk_hop_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- TW_W, 12, tuning-word width.
- DEPTH, 8, hop-table entries.
- DWELL_W, 16, dwell-count width.
REQ-002 Ports, one per line: name, direction, width, meaning:
- clk, in, 1, clock.
- reset, in, 1, asynchronous active-high reset.
- cfg_we, in, 1, table write strobe.
- cfg_addr, in, 3, table entry index.
- cfg_tw, in, TW_W, tuning word to store.
- cfg_dwell, in, DWELL_W, dwell cycles to store.
- num_entries, in, 4, active entry count, sampled at start.
- loop, in, 1, restart at entry 0 after the last entry, sampled at start.
- start, in, 1, begin the sequence (pulse).
- stop, in, 1, abort the sequence (pulse).
- control, out, TW_W signed, tuning word to the NCO.
- tw_valid, out, 1, control holds a new word.
- tw_ready, in, 1, NCO accepts the word.
- hop_idx, out, 3, current entry index.
- busy, out, 1, sequencer is not IDLE.
- done, out, 1, one-cycle end-of-sequence pulse.

Function
REQ-003 The sequencer SHALL hold a DEPTH-entry table of {tw, dwell} pairs.
- Write on cfg_we when busy=0.
- Writes while busy=1 are ignored.
- Written data is readable on the next cycle.
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD, DWELL, DONE.
REQ-005 In IDLE, start=1 with num_entries≠0 SHALL do the following:
- Latch N = min(num_entries, DEPTH) and latch loop.
- Set idx=0 and enter LOAD on the next edge.
REQ-006 In IDLE, start with num_entries=0 SHALL be ignored.
REQ-007 On entry to LOAD, the sequencer SHALL set the following on the same edge:
- control = table[idx].tw.
- tw_valid = 1.
REQ-008 In LOAD, control and tw_valid SHALL stay constant until tw_valid&tw_ready.
REQ-009 On a LOAD handshake, the sequencer SHALL do the following on that edge:
- Deassert tw_valid.
- Load the dwell counter with table[idx].dwell.
- Enter DWELL.
A dwell value of 0 is treated as 1.
REQ-010 DWELL SHALL last exactly max(dwell,1) cycles, and control SHALL hold table[idx].tw throughout.
REQ-011 At dwell expiry, the next state SHALL be:
- idx<N-1: idx+1, then LOAD.
- idx=N-1 with loop=1: idx=0, then LOAD.
- idx=N-1 with loop=0: DONE.
REQ-012 DONE SHALL assert done for one cycle, then enter IDLE.
REQ-013 In IDLE and DONE, control SHALL keep the last issued word so the NCO frequency is continuous.
REQ-014 stop=1 in any non-IDLE state SHALL take effect on the next edge:
- Enter IDLE.
- Deassert tw_valid.
- Do not pulse done.
- Keep control unchanged.
REQ-015 If stop and start are high together, stop SHALL take priority.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 busy SHALL be 1 in the LOAD, DWELL and DONE states.
REQ-018 hop_idx SHALL equal idx in every state.
REQ-019 The dwell counter SHALL be DWELL_W bits unsigned, with no wrap; the maximum dwell is 2^DWELL_W−1 cycles.
REQ-020 Latency from start to the first tw_valid SHALL be 1 cycle.
REQ-021 The gap from dwell expiry to the next tw_valid SHALL be 0 cycles.
REQ-022 cfg_addr values ≥ DEPTH SHALL be ignored.

Reset
REQ-023 Reset SHALL act asynchronously and set the following:
- State IDLE.
- control=0, tw_valid=0, done=0, busy=0, hop_idx=0.
- Dwell counter 0.
- All table entries {0,0}.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence immediately with no done pulse.
REQ-025 The first start after reset is released SHALL behave as specified in REQ-005.

Verification
REQ-026 Table {94,5},{12,3}; N=2, loop=0; tw_ready tied to 1; start pulse. Required response:
- control: 94 for 6 cycles, then 12 for 4 cycles.
- done pulses once, then busy=0.
- control stays 12 afterwards.
REQ-027 Same table, loop=1. Required response:
- The control pattern 94,12 repeats indefinitely.
- hop_idx follows 0,1,0,1.
- stop during the third hop returns IDLE on the next cycle, tw_valid=0, no done pulse.
REQ-028 tw_ready held low for 4 cycles after tw_valid rises. Required response:
- control and tw_valid stay stable.
- The dwell starts only on the handshake cycle.
REQ-029 Entry with dwell=0, plus start with num_entries=0 and with num_entries=12. Required response:
- dwell=0 gives a 1-cycle dwell.
- num_entries=0 gives busy=0 and is ignored.
- num_entries=12 clamps to 8 hops.
REQ-030 cfg_we while busy, and reset asserted mid-DWELL. Required response:
- The write while busy leaves the table unchanged.
- Reset mid-DWELL forces all outputs to their reset values immediately, asynchronously to clk.

Source files
------------

// File: rtl/fsk_hop_sequencer.sv
// Frequency-hop sequencer: steps an NCO through a table of {tuning word, dwell}
// pairs, handing each word over with a valid/ready handshake before its dwell starts.
module fsk_hop_sequencer #(
  parameter int TW_W    = 12,
  parameter int DEPTH   = 8,
  parameter int DWELL_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_we,
  input  logic [2:0]                cfg_addr,
  input  logic signed [TW_W-1:0]    cfg_tw,
  input  logic [DWELL_W-1:0]        cfg_dwell,
  input  logic [3:0]                num_entries,
  input  logic                      loop,
  input  logic                      start,
  input  logic                      stop,
  output logic signed [TW_W-1:0]    control,
  output logic                      tw_valid,
  input  logic                      tw_ready,
  output logic [2:0]                hop_idx,
  output logic                      busy,
  output logic                      done
);

  typedef enum logic [1:0] {IDLE, LOAD, DWELL, DONE} state_t;

  state_t                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [2:0]               last_q, last_d;
  logic                     loop_q, loop_d;
  logic [DWELL_W-1:0]       cnt_q, cnt_d;
  logic signed [TW_W-1:0]   control_q, control_d;

  logic signed [TW_W-1:0]   tw_mem_q    [DEPTH];
  logic [DWELL_W-1:0]       dwell_mem_q [DEPTH];
  logic                     tbl_we;

  // A programmed dwell of zero still occupies one cycle.
  function automatic logic [DWELL_W-1:0] dwell_floor1(input logic [DWELL_W-1:0] d);
    return (d == '0) ? DWELL_W'(1) : d;
  endfunction

  function automatic logic [2:0] last_index(input logic [3:0] n);
    if (int'(n) > DEPTH) return 3'(DEPTH - 1);
    return 3'(n - 4'd1);
  endfunction

  assign tbl_we = cfg_we && (state_q == IDLE) && (int'(cfg_addr) < DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tw_mem_q[i]    <= '0;
        dwell_mem_q[i] <= '0;
      end
    end else if (tbl_we) begin
      tw_mem_q[cfg_addr]    <= cfg_tw;
      dwell_mem_q[cfg_addr] <= cfg_dwell;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    loop_d    = loop_q;
    cnt_d     = cnt_q;
    control_d = control_q;
    case (state_q)
      IDLE: begin
        if (start && !stop && (num_entries != 4'd0)) begin
          last_d    = last_index(num_entries);
          loop_d    = loop;
          idx_d     = 3'd0;
          control_d = tw_mem_q[3'd0];
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else if (tw_ready) begin
          cnt_d   = dwell_floor1(dwell_mem_q[idx_q]);
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q > DWELL_W'(1)) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
          // Expiry: the next word is issued on this same edge, no gap cycle.
          cnt_d = '0;
          if (idx_q != last_q) begin
            idx_d     = idx_q + 3'd1;
            control_d = tw_mem_q[idx_q + 3'd1];
            state_d   = LOAD;
          end else if (loop_q) begin
            idx_d     = 3'd0;
            control_d = tw_mem_q[3'd0];
            state_d   = LOAD;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      loop_q    <= 1'b0;
      cnt_q     <= '0;
      control_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      loop_q    <= loop_d;
      cnt_q     <= cnt_d;
      control_q <= control_d;
    end
  end

  // control is never cleared outside reset so the NCO frequency stays continuous.
  assign control  = control_q;
  assign tw_valid = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign hop_idx  = idx_q;

endmodule

// File: tb/tb_fsk_hop_sequencer.sv
// Directed bench for fsk_hop_sequencer: a timestamp-based hop model checked every
// cycle, plus literal expectations for the documented hop scenarios.
module tb_fsk_hop_sequencer;
  localparam int TW_W    = 12;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   cfg_we = 1'b0;
  logic [2:0]             cfg_addr = '0;
  logic signed [TW_W-1:0] cfg_tw = '0;
  logic [DWELL_W-1:0]     cfg_dwell = '0;
  logic [3:0]             num_entries = '0;
  logic                   loop = 1'b0;
  logic                   start = 1'b0;
  logic                   stop = 1'b0;
  logic signed [TW_W-1:0] control;
  logic                   tw_valid;
  logic                   tw_ready = 1'b1;
  logic [2:0]             hop_idx;
  logic                   busy;
  logic                   done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fsk_hop_sequencer #(.TW_W(TW_W), .DEPTH(DEPTH), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_tw(cfg_tw),
    .cfg_dwell(cfg_dwell), .num_entries(num_entries), .loop(loop), .start(start),
    .stop(stop), .control(control), .tw_valid(tw_valid), .tw_ready(tw_ready),
    .hop_idx(hop_idx), .busy(busy), .done(done)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // Model: a run is a list of hops; each hop is issued, accepted at some cycle,
  // and ends a fixed number of cycles after acceptance.
  int m_tw [DEPTH];
  int m_dw [DEPTH];
  bit m_run, m_acc, m_donep, m_loop;
  int m_idx, m_n, m_ctrl, m_end, cyc;

  task automatic issue(input int i);
    m_idx  = i;
    m_ctrl = m_tw[i];
    m_acc  = 1'b0;
  endtask

  task automatic model_step();
    bit was_busy, wr;
    int wa, wt, wd;
    cyc++;
    if (reset) begin
      m_run = 0; m_acc = 0; m_donep = 0; m_loop = 0;
      m_idx = 0; m_n = 0; m_ctrl = 0; m_end = 0;
      for (int i = 0; i < DEPTH; i++) begin
        m_tw[i] = 0;
        m_dw[i] = 0;
      end
      return;
    end
    was_busy = m_run || m_donep;
    wr = cfg_we && !was_busy && (int'(cfg_addr) < DEPTH);
    wa = int'(cfg_addr);
    wt = int'(cfg_tw);
    wd = int'(cfg_dwell);
    if (m_donep) begin
      m_donep = 1'b0;
    end else if (m_run) begin
      if (stop) begin
        m_run = 1'b0;
      end else if (!m_acc) begin
        if (tw_ready) begin
          m_acc = 1'b1;
          m_end = cyc + ((m_dw[m_idx] == 0) ? 1 : m_dw[m_idx]);
        end
      end else if (cyc == m_end) begin
        if (m_idx < m_n - 1) issue(m_idx + 1);
        else if (m_loop) issue(0);
        else begin
          m_run   = 1'b0;
          m_donep = 1'b1;
        end
      end
    end else if (start && !stop && num_entries != 4'd0) begin
      m_n    = (int'(num_entries) > DEPTH) ? DEPTH : int'(num_entries);
      m_loop = loop;
      m_run  = 1'b1;
      issue(0);
    end
    if (wr) begin
      m_tw[wa] = wt;
      m_dw[wa] = wd;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cyc_busy", int'(busy), int'(m_run || m_donep));
      chk("cyc_tw_valid", int'(tw_valid), int'(m_run && !m_acc));
      chk("cyc_done", int'(done), int'(m_donep));
      chk("cyc_hop_idx", int'(hop_idx), m_idx);
      chk("cyc_control", int'(control), m_ctrl);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_entry(input int a, input int tw, input int dw);
    cfg_we = 1'b1; cfg_addr = 3'(a); cfg_tw = TW_W'(tw); cfg_dwell = DWELL_W'(dw);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start(input int n, input bit lp);
    num_entries = 4'(n); loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) return;
    end
    timeout_fail(nm);
  endtask

  int c94, c12, nd, nv, ndw, nst, nd2;
  int vc [3];
  int vi [3];
  bit hit;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_control", int'(control), 0);
    chk("rst_tw_valid", int'(tw_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_hop_idx", int'(hop_idx), 0);
    @(posedge clk); #2; reset = 1'b0;
    tick();

    // Two hops, no loop, NCO always ready
    wr_entry(0, 94, 5);
    wr_entry(1, 12, 3);
    tw_ready = 1'b1;
    pulse_start(2, 1'b0);
    c94 = 0; c12 = 0; nd = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (busy && !done && control == 94) c94++;
      if (busy && !done && control == 12) c12++;
      if (done) nd++;
    end
    chk("s1_cycles_94", c94, 6);
    chk("s1_cycles_12", c12, 4);
    chk("s1_done_pulses", nd, 1);
    chk("s1_busy_after", int'(busy), 0);
    chk("s1_control_after", int'(control), 12);

    // Looping, then stop during the third hop
    pulse_start(2, 1'b1);
    nv = 0;
    for (int k = 0; k < 40 && nv < 3; k++) begin
      @(negedge clk);
      if (tw_valid) begin
        vc[nv] = int'(control);
        vi[nv] = int'(hop_idx);
        nv++;
      end
    end
    if (nv < 3) timeout_fail("s2_third_hop");
    chk("s2_hop0_control", vc[0], 94);
    chk("s2_hop1_control", vc[1], 12);
    chk("s2_hop2_control", vc[2], 94);
    chk("s2_hop0_idx", vi[0], 0);
    chk("s2_hop1_idx", vi[1], 1);
    chk("s2_hop2_idx", vi[2], 0);
    @(negedge clk);
    @(negedge clk);
    stop = 1'b1;
    @(posedge clk); #2; stop = 1'b0;
    @(negedge clk);
    chk("s2_stop_busy", int'(busy), 0);
    chk("s2_stop_tw_valid", int'(tw_valid), 0);
    chk("s2_stop_done", int'(done), 0);
    chk("s2_stop_control", int'(control), 94);
    tick();

    // NCO stalls: ready low while the word is offered
    tw_ready = 1'b0;
    pulse_start(1, 1'b0);
    nv = 0; ndw = 0; nst = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (tw_valid) begin
        nv++;
        if (control == 94) nst++;
        if (nv == 5) tw_ready = 1'b1;
      end else if (!done) begin
        ndw++;
      end
    end
    tw_ready = 1'b1;
    chk("s3_valid_cycles", nv, 5);
    chk("s3_stable_control", nst, 5);
    chk("s3_dwell_cycles", ndw, 5);
    tick();

    // Zero dwell, zero entries, clamped entry count
    for (int i = 0; i < 8; i++) wr_entry(i, 100 + 7 * i, (i == 2) ? 0 : 2);
    pulse_start(0, 1'b0);
    @(negedge clk);
    chk("s4_n0_busy_a", int'(busy), 0);
    @(negedge clk);
    chk("s4_n0_busy_b", int'(busy), 0);
    tick();
    pulse_start(12, 1'b0);
    nv = 0; nd2 = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      if (tw_valid) nv++;
      else if (!done && hop_idx == 3'd2) nd2++;
    end
    chk("s4_hops", nv, 8);
    chk("s4_dwell0_cycles", nd2, 1);
    chk("s4_last_control", int'(control), 149);
    tick();

    // Write while busy is dropped
    pulse_start(2, 1'b0);
    wr_entry(0, 555, 9);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick();
    pulse_start(2, 1'b0);
    @(negedge clk);
    chk("s5_load_valid", int'(tw_valid), 1);
    chk("s5_table_kept", int'(control), 100);

    // Asynchronous reset in the middle of the second hop's dwell
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (hop_idx == 3'd1 && !tw_valid && busy) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) timeout_fail("s5_reach_dwell");
    #2; reset = 1'b1;
    #1;
    chk("s5_async_control", int'(control), 0);
    chk("s5_async_tw_valid", int'(tw_valid), 0);
    chk("s5_async_busy", int'(busy), 0);
    chk("s5_async_done", int'(done), 0);
    chk("s5_async_hop_idx", int'(hop_idx), 0);
    @(posedge clk); #2; reset = 1'b0;
    tick();

    // First start after reset runs from a cleared table
    pulse_start(1, 1'b0);
    @(negedge clk);
    chk("s6_post_reset_valid", int'(tw_valid), 1);
    chk("s6_post_reset_control", int'(control), 0);
    wait_idle("s6_idle", 20);
    wr_entry(0, -300, 2);
    pulse_start(1, 1'b0);
    @(negedge clk);
    chk("s6_negative_word", int'(control), -300);
    wait_idle("s6_idle2", 20);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
